// File: rtl/adc_delay_cal_ctrl_pkg.sv
// Shared constants for the ADC IDELAY calibration slice.
// Packed DDR word layout, FSM state codes and the word pass rule.
package adc_cal_pkg;

    localparam int DEF_TAP_W = 5;
    localparam int ADC_W     = 26;
    localparam int SMP_W     = 12;

    localparam int OVR0_BIT = 0;
    localparam int S0_LSB   = 1;
    localparam int S0_MSB   = 12;
    localparam int OVR1_BIT = 13;
    localparam int S1_LSB   = 14;
    localparam int S1_MSB   = 25;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] SETTLE = 3'd2;
    localparam logic [2:0] SAMPLE = 3'd3;
    localparam logic [2:0] EVAL   = 3'd4;
    localparam logic [2:0] CENTER = 3'd5;
    localparam logic [2:0] APPLY  = 3'd6;

    function automatic logic word_ok(
        input logic [ADC_W-1:0] d,
        input logic [SMP_W-1:0] p
    );
        return (d[S0_MSB:S0_LSB] == p)
            && (d[S1_MSB:S1_LSB] == p)
            && !d[OVR0_BIT]
            && !d[OVR1_BIT];
    endfunction

endpackage

// File: rtl/adc_delay_cal_ctrl_if.sv
// Control/data bundle between register block, ADC buffer and calibrator.
// master = register block / buffer side, slave = calibration controller.
interface adc_cal_if #(
    parameter int TAP_W = adc_cal_pkg::DEF_TAP_W
);
    logic                  cal_start;
    logic                  cal_abort;
    logic [11:0]           test_pattern;
    logic [TAP_W-1:0]      manual_tap;
    logic                  manual_tap_wr;
    logic [25:0]           adc_dat;
    logic [TAP_W-1:0]      delay_tap;
    logic                  delay_load;
    logic                  cal_busy;
    logic                  cal_done;
    logic                  cal_fail;
    logic [TAP_W-1:0]      win_start;
    logic [TAP_W:0]        win_len;
    logic [2**TAP_W-1:0]   tap_pass_map;

    modport master (
        output cal_start, cal_abort, test_pattern,
        output manual_tap, manual_tap_wr, adc_dat,
        input  delay_tap, delay_load, cal_busy,
        input  cal_done, cal_fail, win_start,
        input  win_len, tap_pass_map
    );

    modport slave (
        input  cal_start, cal_abort, test_pattern,
        input  manual_tap, manual_tap_wr, adc_dat,
        output delay_tap, delay_load, cal_busy,
        output cal_done, cal_fail, win_start,
        output win_len, tap_pass_map
    );

endinterface

// File: rtl/adc_delay_cal_ctrl_window_tracker.sv
// Longest-contiguous-pass-window tracker for the tap sweep.
// Taps are linear: the run is dropped after the last tap, never wrapped.
module adc_cal_window_tracker
    import adc_cal_pkg::*;
#(
    parameter int TAP_W = DEF_TAP_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pass,
    input  logic             step,
    input  logic             clear,
    input  logic             last,
    output logic [TAP_W-1:0] best_start,
    output logic [TAP_W:0]   best_len,
    output logic [TAP_W-1:0] centre
);

    logic [TAP_W-1:0] tap_q, tap_d;
    logic [TAP_W-1:0] run_start_q, run_start_d;
    logic [TAP_W:0]   run_len_q, run_len_d;
    logic [TAP_W-1:0] best_start_q, best_start_d;
    logic [TAP_W:0]   best_len_q, best_len_d;

    always_comb begin
        tap_d        = tap_q;
        run_start_d  = run_start_q;
        run_len_d    = run_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        if (clear) begin
            tap_d        = '0;
            run_start_d  = '0;
            run_len_d    = '0;
            best_start_d = '0;
            best_len_d   = '0;
        end else if (step) begin
            if (pass) begin
                run_len_d = run_len_q + 1'b1;
                if (run_len_q == '0)
                    run_start_d = tap_q;
            end else begin
                run_len_d = '0;
            end
            // strict compare: ties keep the earliest window
            if (run_len_d > best_len_q) begin
                best_len_d   = run_len_d;
                best_start_d = run_start_d;
            end
            tap_d = tap_q + 1'b1;
            if (last) begin
                tap_d     = '0;
                run_len_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tap_q        <= '0;
            run_start_q  <= '0;
            run_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
        end else begin
            tap_q        <= tap_d;
            run_start_q  <= run_start_d;
            run_len_q    <= run_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
        end
    end

    assign best_start = best_start_q;
    assign best_len   = best_len_q;
    assign centre     = best_start_q
                      + TAP_W'((best_len_q - 1'b1) >> 1);

endmodule

// File: rtl/adc_delay_cal_ctrl.sv
// IDELAY tap sweep/centre calibration for one ADC channel (adc_clk domain).
// Define ADC_CAL_ERRMAP_EN to build the per-tap pass map output.
module adc_delay_cal_ctrl
    import adc_cal_pkg::*;
#(
    parameter int TAP_W           = DEF_TAP_W,
    parameter int SETTLE_CYCLES   = 16,
    parameter int SAMPLES_PER_TAP = 256,
    parameter int MIN_WIN         = 4
) (
    input  logic   clk,
    input  logic   reset_n,
    adc_cal_if.slave bus
);

    localparam int CW = $clog2(SETTLE_CYCLES + SAMPLES_PER_TAP + 1);
    localparam logic [TAP_W-1:0] LAST_TAP = {TAP_W{1'b1}};

    logic [2:0]       state_q, state_d;
    logic [TAP_W-1:0] cnt_q, cnt_d;
    logic [CW-1:0]    cyc_q, cyc_d;
    logic             err_q, err_d;
    logic [TAP_W-1:0] saved_q, saved_d;
    logic [TAP_W-1:0] target_q, target_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic             load_q, load_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fail_q, fail_d;
    logic [TAP_W-1:0] wstart_q, wstart_d;
    logic [TAP_W:0]   wlen_q, wlen_d;

    logic             trk_step, trk_clear;
    logic [TAP_W-1:0] best_start, centre;
    logic [TAP_W:0]   best_len;

    adc_cal_window_tracker #(.TAP_W(TAP_W)) u_trk (
        .clk        (clk),
        .reset_n    (reset_n),
        .pass       (!err_q),
        .step       (trk_step),
        .clear      (trk_clear),
        .last       (cnt_q == LAST_TAP),
        .best_start (best_start),
        .best_len   (best_len),
        .centre     (centre)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cyc_d     = cyc_q;
        err_d     = err_q;
        saved_d   = saved_q;
        target_d  = target_q;
        tap_d     = tap_q;
        load_d    = 1'b0;
        busy_d    = busy_q;
        done_d    = done_q;
        fail_d    = fail_q;
        wstart_d  = wstart_q;
        wlen_d    = wlen_q;
        trk_step  = 1'b0;
        trk_clear = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                // start outranks a simultaneous manual write
                if (bus.cal_start) begin
                    saved_d   = tap_q;
                    done_d    = 1'b0;
                    fail_d    = 1'b0;
                    wstart_d  = '0;
                    wlen_d    = '0;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    trk_clear = 1'b1;
                    state_d   = LOAD;
                end else if (bus.manual_tap_wr) begin
                    tap_d  = bus.manual_tap;
                    load_d = 1'b1;
                end
            end
            LOAD: begin
                tap_d   = cnt_q;
                load_d  = 1'b1;
                cyc_d   = '0;
                state_d = SETTLE;
            end
            SETTLE: begin
                cyc_d = cyc_q + 1'b1;
                if (cyc_q == CW'(SETTLE_CYCLES - 1)) begin
                    cyc_d   = '0;
                    err_d   = 1'b0;
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                cyc_d = cyc_q + 1'b1;
                if (!word_ok(bus.adc_dat, bus.test_pattern))
                    err_d = 1'b1;
                if (cyc_q == CW'(SAMPLES_PER_TAP - 1))
                    state_d = EVAL;
            end
            EVAL: begin
                trk_step = 1'b1;
                if (cnt_q == LAST_TAP) begin
                    state_d = CENTER;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = LOAD;
                end
            end
            CENTER: begin
                wstart_d = best_start;
                wlen_d   = best_len;
                if (best_len >= (TAP_W+1)'(MIN_WIN)) begin
                    target_d = centre;
                    done_d   = 1'b1;
                end else begin
                    target_d = saved_q;
                    fail_d   = 1'b1;
                end
                state_d = APPLY;
            end
            APPLY: begin
                tap_d   = target_q;
                load_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.cal_abort && state_q != IDLE
                && state_q != APPLY) begin
            state_d  = APPLY;
            target_d = saved_q;
            fail_d   = 1'b1;
            done_d   = 1'b0;
            tap_d    = tap_q;
            load_d   = 1'b0;
            trk_step = 1'b0;
            wstart_d = wstart_q;
            wlen_d   = wlen_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cyc_q    <= '0;
            err_q    <= 1'b0;
            saved_q  <= '0;
            target_q <= '0;
            tap_q    <= '0;
            load_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fail_q   <= 1'b0;
            wstart_q <= '0;
            wlen_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cyc_q    <= cyc_d;
            err_q    <= err_d;
            saved_q  <= saved_d;
            target_q <= target_d;
            tap_q    <= tap_d;
            load_q   <= load_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            fail_q   <= fail_d;
            wstart_q <= wstart_d;
            wlen_q   <= wlen_d;
        end
    end

`ifdef ADC_CAL_ERRMAP_EN
    logic [2**TAP_W-1:0] map_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            map_q <= '0;
        else if (trk_clear)
            map_q <= '0;
        else if (trk_step)
            map_q[cnt_q] <= !err_q;
    end

    assign bus.tap_pass_map = map_q;
`else
    assign bus.tap_pass_map = '0;
`endif

    assign bus.delay_tap  = tap_q;
    assign bus.delay_load = load_q;
    assign bus.cal_busy   = busy_q;
    assign bus.cal_done   = done_q;
    assign bus.cal_fail   = fail_q;
    assign bus.win_start  = wstart_q;
    assign bus.win_len    = wlen_q;

endmodule

// File: tb/tb_adc_delay_cal_ctrl.sv
// Directed bench for adc_delay_cal_ctrl; ADC data is modelled from delay_tap.
module tb_adc_delay_cal_ctrl;

    logic clk = 1'b0;
    logic reset_n;
    logic [31:0] pass_mask;
    logic inj;
    int total = 0;
    int bad = 0;

`ifdef ADC_CAL_ERRMAP_EN
    localparam bit ERRMAP = 1'b1;
`else
    localparam bit ERRMAP = 1'b0;
`endif

    always #5 clk = ~clk;

    adc_cal_if #(.TAP_W(5)) bus ();

    adc_delay_cal_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always_comb begin
        bus.adc_dat = {bus.test_pattern, 1'b0, bus.test_pattern, 1'b0};
        if (!pass_mask[bus.delay_tap])
            bus.adc_dat[25:14] = ~bus.test_pattern;
        if (inj)
            bus.adc_dat[13] = 1'b1;
    end

    task automatic start_cal();
        bus.cal_start = 1'b1;
        @(negedge clk);
        bus.cal_start = 1'b0;
    endtask

    task automatic wait_idle(output int loads, output int cyc);
        loads = 0;
        cyc = 0;
        while (bus.cal_busy && cyc < 20000) begin
            if (bus.delay_load) loads++;
            @(negedge clk);
            cyc++;
        end
        total++;
        if (bus.cal_busy) begin
            $display("FAIL idle_timeout busy=%0b after %0d cycles", bus.cal_busy, cyc);
            bad++;
        end
    endtask

    task automatic wait_tap(input int t);
        int n = 0;
        while (!(bus.delay_load && bus.delay_tap == 5'(t)) && n < 10000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 10000) begin
            $display("FAIL tap_timeout tap=%0d want=%0d", bus.delay_tap, t);
            bad++;
        end
    endtask

    task automatic manual_wr(input logic [4:0] v);
        bus.manual_tap = v;
        bus.manual_tap_wr = 1'b1;
        @(negedge clk);
        bus.manual_tap_wr = 1'b0;
        total += 3;
        if (bus.delay_tap !== v) begin
            $display("FAIL wr_tap got=%0d want=%0d", bus.delay_tap, v); bad++;
        end
        if (bus.delay_load !== 1'b1) begin
            $display("FAIL wr_load got=%0b want=1", bus.delay_load); bad++;
        end
        @(negedge clk);
        if (bus.delay_load !== 1'b0) begin
            $display("FAIL wr_load_end got=%0b want=0", bus.delay_load); bad++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total += 8;
        if (bus.delay_tap !== 5'd0) begin $display("FAIL rst_tap got=%0d want=0", bus.delay_tap); bad++; end
        if (bus.delay_load !== 1'b0) begin $display("FAIL rst_load got=%0b want=0", bus.delay_load); bad++; end
        if (bus.cal_busy !== 1'b0) begin $display("FAIL rst_busy got=%0b want=0", bus.cal_busy); bad++; end
        if (bus.cal_done !== 1'b0) begin $display("FAIL rst_done got=%0b want=0", bus.cal_done); bad++; end
        if (bus.cal_fail !== 1'b0) begin $display("FAIL rst_fail got=%0b want=0", bus.cal_fail); bad++; end
        if (bus.win_start !== 5'd0) begin $display("FAIL rst_wstart got=%0d want=0", bus.win_start); bad++; end
        if (bus.win_len !== 6'd0) begin $display("FAIL rst_wlen got=%0d want=0", bus.win_len); bad++; end
        if (bus.tap_pass_map !== 32'd0) begin $display("FAIL rst_map got=%h want=0", bus.tap_pass_map); bad++; end
    endtask

    task automatic test_window();
        int loads, cyc;
        logic [31:0] exp_map;
        pass_mask = 32'h000F_FC00;
        exp_map = ERRMAP ? 32'h000F_FC00 : 32'h0;
        start_cal();
        total++;
        if (bus.cal_busy !== 1'b1) begin $display("FAIL win_busy got=%0b want=1", bus.cal_busy); bad++; end
        wait_idle(loads, cyc);
        total += 8;
        if (bus.cal_done !== 1'b1) begin $display("FAIL win_done got=%0b want=1", bus.cal_done); bad++; end
        if (bus.cal_fail !== 1'b0) begin $display("FAIL win_fail got=%0b want=0", bus.cal_fail); bad++; end
        if (bus.win_start !== 5'd10) begin $display("FAIL win_start got=%0d want=10", bus.win_start); bad++; end
        if (bus.win_len !== 6'd10) begin $display("FAIL win_len got=%0d want=10", bus.win_len); bad++; end
        if (bus.delay_tap !== 5'd14) begin $display("FAIL win_tap got=%0d want=14", bus.delay_tap); bad++; end
        if (loads != 33) begin $display("FAIL win_loads got=%0d want=33", loads); bad++; end
        if (cyc != 8771) begin $display("FAIL win_cycles got=%0d want=8771", cyc); bad++; end
        if (bus.tap_pass_map !== exp_map) begin $display("FAIL win_map got=%h want=%h", bus.tap_pass_map, exp_map); bad++; end
    endtask

    task automatic test_tie();
        int loads, cyc;
        pass_mask = 32'h03F0_01F8;
        start_cal();
        wait_idle(loads, cyc);
        total += 4;
        if (bus.win_start !== 5'd3) begin $display("FAIL tie_start got=%0d want=3", bus.win_start); bad++; end
        if (bus.win_len !== 6'd6) begin $display("FAIL tie_len got=%0d want=6", bus.win_len); bad++; end
        if (bus.delay_tap !== 5'd5) begin $display("FAIL tie_tap got=%0d want=5", bus.delay_tap); bad++; end
        if (bus.cal_done !== 1'b1) begin $display("FAIL tie_done got=%0b want=1", bus.cal_done); bad++; end
    endtask

    task automatic test_fail();
        int loads, cyc;
        manual_wr(5'd7);
        pass_mask = 32'h0000_0007;
        start_cal();
        wait_idle(loads, cyc);
        total += 6;
        if (bus.cal_fail !== 1'b1) begin $display("FAIL fail_flag got=%0b want=1", bus.cal_fail); bad++; end
        if (bus.cal_done !== 1'b0) begin $display("FAIL fail_done got=%0b want=0", bus.cal_done); bad++; end
        if (bus.win_len !== 6'd3) begin $display("FAIL fail_len got=%0d want=3", bus.win_len); bad++; end
        if (bus.win_start !== 5'd0) begin $display("FAIL fail_start got=%0d want=0", bus.win_start); bad++; end
        if (bus.delay_tap !== 5'd7) begin $display("FAIL fail_tap got=%0d want=7", bus.delay_tap); bad++; end
        if (loads != 33) begin $display("FAIL fail_loads got=%0d want=33", loads); bad++; end
    endtask

    task automatic test_all_pass();
        int loads, cyc;
        logic [31:0] exp_map;
        pass_mask = 32'hFFFF_FFFF;
        start_cal();
        wait_idle(loads, cyc);
        total += 4;
        if (bus.win_start !== 5'd0) begin $display("FAIL all_start got=%0d want=0", bus.win_start); bad++; end
        if (bus.win_len !== 6'd32) begin $display("FAIL all_len got=%0d want=32", bus.win_len); bad++; end
        if (bus.delay_tap !== 5'd15) begin $display("FAIL all_tap got=%0d want=15", bus.delay_tap); bad++; end
        if (bus.cal_done !== 1'b1) begin $display("FAIL all_done got=%0b want=1", bus.cal_done); bad++; end
        exp_map = ERRMAP ? 32'h7FFF_FFFF : 32'h0;
        start_cal();
        wait_tap(31);
        repeat (100) @(negedge clk);
        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        wait_idle(loads, cyc);
        total += 5;
        if (bus.win_start !== 5'd0) begin $display("FAIL ovr_start got=%0d want=0", bus.win_start); bad++; end
        if (bus.win_len !== 6'd31) begin $display("FAIL ovr_len got=%0d want=31", bus.win_len); bad++; end
        if (bus.delay_tap !== 5'd15) begin $display("FAIL ovr_tap got=%0d want=15", bus.delay_tap); bad++; end
        if (bus.cal_done !== 1'b1) begin $display("FAIL ovr_done got=%0b want=1", bus.cal_done); bad++; end
        if (bus.tap_pass_map !== exp_map) begin $display("FAIL ovr_map got=%h want=%h", bus.tap_pass_map, exp_map); bad++; end
    endtask

    task automatic test_abort();
        manual_wr(5'd12);
        start_cal();
        wait_tap(9);
        repeat (40) @(negedge clk);
        start_cal();
        @(negedge clk);
        total += 3;
        if (bus.delay_tap !== 5'd9) begin $display("FAIL ign_tap got=%0d want=9", bus.delay_tap); bad++; end
        if (bus.delay_load !== 1'b0) begin $display("FAIL ign_load got=%0b want=0", bus.delay_load); bad++; end
        if (bus.cal_busy !== 1'b1) begin $display("FAIL ign_busy got=%0b want=1", bus.cal_busy); bad++; end
        bus.cal_abort = 1'b1;
        @(negedge clk);
        bus.cal_abort = 1'b0;
        total += 2;
        if (bus.cal_busy !== 1'b1) begin $display("FAIL ab_busy1 got=%0b want=1", bus.cal_busy); bad++; end
        if (bus.delay_load !== 1'b0) begin $display("FAIL ab_load1 got=%0b want=0", bus.delay_load); bad++; end
        @(negedge clk);
        total += 2;
        if (bus.delay_load !== 1'b1) begin $display("FAIL ab_load2 got=%0b want=1", bus.delay_load); bad++; end
        if (bus.delay_tap !== 5'd12) begin $display("FAIL ab_tap got=%0d want=12", bus.delay_tap); bad++; end
        @(negedge clk);
        total += 4;
        if (bus.cal_busy !== 1'b0) begin $display("FAIL ab_busy3 got=%0b want=0", bus.cal_busy); bad++; end
        if (bus.delay_load !== 1'b0) begin $display("FAIL ab_load3 got=%0b want=0", bus.delay_load); bad++; end
        if (bus.cal_fail !== 1'b1) begin $display("FAIL ab_fail got=%0b want=1", bus.cal_fail); bad++; end
        if (bus.cal_done !== 1'b0) begin $display("FAIL ab_done got=%0b want=0", bus.cal_done); bad++; end
    endtask

    task automatic test_reset_mid();
        start_cal();
        wait_tap(1);
        repeat (5) @(negedge clk);
        total++;
        if (bus.cal_busy !== 1'b1) begin $display("FAIL mid_busy_pre got=%0b want=1", bus.cal_busy); bad++; end
        #2;
        reset_n = 1'b0;
        #1;
        total += 5;
        if (bus.delay_tap !== 5'd0) begin $display("FAIL mid_tap got=%0d want=0", bus.delay_tap); bad++; end
        if (bus.cal_busy !== 1'b0) begin $display("FAIL mid_busy got=%0b want=0", bus.cal_busy); bad++; end
        if (bus.delay_load !== 1'b0) begin $display("FAIL mid_load got=%0b want=0", bus.delay_load); bad++; end
        if (bus.cal_fail !== 1'b0) begin $display("FAIL mid_fail got=%0b want=0", bus.cal_fail); bad++; end
        if (bus.win_len !== 6'd0) begin $display("FAIL mid_wlen got=%0d want=0", bus.win_len); bad++; end
        @(negedge clk);
        reset_n = 1'b1;
        manual_wr(5'd21);
        total++;
        if (bus.cal_busy !== 1'b0) begin $display("FAIL mid_busy_post got=%0b want=0", bus.cal_busy); bad++; end
    endtask

    initial begin
        reset_n = 1'b0;
        bus.cal_start = 1'b0;
        bus.cal_abort = 1'b0;
        bus.test_pattern = 12'hA5C;
        bus.manual_tap = '0;
        bus.manual_tap_wr = 1'b0;
        pass_mask = '0;
        inj = 1'b0;
        test_reset();
        test_window();
        test_tie();
        test_fail();
        test_all_pass();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
